// File: rtl/watermelon_motion_ctrl_pkg.sv
// watermelon_motion_ctrl_pkg
//   Shared constants for the watermelon sprite motion controller and the OLED
//   renderers: screen and sprite geometry, motion tuning, the controller state
//   encoding and the RGB565 colour constants.
//   No ports (package).
package watermelon_motion_ctrl_pkg;

  localparam int SCREEN_W  = 96;
  localparam int SCREEN_H  = 64;
  localparam int SPRITE_W  = 56;
  localparam int SPRITE_H  = 58;
  localparam int MAX_X     = SCREEN_W - SPRITE_W;  // 40
  localparam int MAX_Y     = SCREEN_H - SPRITE_H;  // 6

  localparam int STEP_X    = 2;
  localparam int STEP_Y    = 1;
  localparam int FRAME_DIV = 2;
  localparam int INIT_X    = 20;
  localparam int INIT_Y    = 3;

  localparam int X_W       = 7;
  localparam int Y_W       = 6;

  // A divide-by-1 still needs a 1-bit counter so the compare stays legal.
  localparam int DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  // RGB565 colours shared with the renderers.
  localparam logic [15:0] COL_BLACK = 16'h0000;
  localparam logic [15:0] COL_WHITE = 16'hFFFF;
  localparam logic [15:0] COL_RED   = 16'hF800;
  localparam logic [15:0] COL_GREEN = 16'h07E0;

endpackage

// File: rtl/watermelon_motion_ctrl_if.sv
// watermelon_motion_ctrl_if
//   Bundles the button/frame controls going into the motion controller and the
//   sprite anchor/status going out to the renderer.
//   Signals:
//     frame_tick, start, pause, stop : one-cycle pulses into the controller
//     leftX_watermelon[6:0], topY_watermelon[5:0] : sprite anchor
//     dir_x, dir_y, moving, update_pulse          : status
//   Modports: master = button/frame side (drives controls), slave = controller.
interface watermelon_motion_ctrl_if;
  import watermelon_motion_ctrl_pkg::*;

  logic           frame_tick;
  logic           start;
  logic           pause;
  logic           stop;
  logic [X_W-1:0] leftX_watermelon;
  logic [Y_W-1:0] topY_watermelon;
  logic           dir_x;
  logic           dir_y;
  logic           moving;
  logic           update_pulse;

  modport master (
    output frame_tick, start, pause, stop,
    input  leftX_watermelon, topY_watermelon, dir_x, dir_y, moving, update_pulse
  );

  modport slave (
    input  frame_tick, start, pause, stop,
    output leftX_watermelon, topY_watermelon, dir_x, dir_y, moving, update_pulse
  );

endinterface

// File: rtl/watermelon_motion_ctrl_bounce_axis.sv
// watermelon_motion_ctrl_bounce_axis
//   One axis of the bouncing anchor. Moves pos by STEP per step_en toward the
//   current direction, clamping to 0..MAX and reversing at either edge.
//   Ports:
//     CLOCK     in  system clock
//     RESET     in  synchronous active-high reset (pos=INIT, dir=1)
//     load_init in  return to INIT, direction forward
//     step_en   in  advance one step this cycle
//     pos       out current position, 0..MAX
//     dir       out 1 = increasing, 0 = decreasing
module watermelon_motion_ctrl_bounce_axis #(
  parameter int W    = 7,
  parameter int MAX  = 40,
  parameter int STEP = 2,
  parameter int INIT = 20
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         load_init,
  input  logic         step_en,
  output logic [W-1:0] pos,
  output logic         dir
);

  // Compares are done one bit wider so pos+STEP can never wrap.
  localparam logic [W:0]   MAX_E  = (W+1)'(MAX);
  localparam logic [W:0]   STEP_E = (W+1)'(STEP);
  localparam logic [W-1:0] MAX_P  = W'(MAX);
  localparam logic [W-1:0] STEP_P = W'(STEP);
  localparam logic [W-1:0] INIT_P = W'(INIT);

  logic [W:0] pos_e;
  logic [W:0] sum_e;

  assign pos_e = {1'b0, pos};
  assign sum_e = pos_e + STEP_E;

  always_ff @(posedge CLOCK) begin
    if (RESET || load_init) begin
      pos <= INIT_P;
      dir <= 1'b1;
    end else if (step_en) begin
      if (dir) begin
        if (sum_e >= MAX_E) begin
          pos <= MAX_P;
          dir <= 1'b0;
        end else begin
          pos <= sum_e[W-1:0];
        end
      end else begin
        if (pos_e <= STEP_E) begin
          pos <= '0;
          dir <= 1'b1;
        end else begin
          pos <= pos - STEP_P;
        end
      end
    end
  end

endmodule

// File: rtl/watermelon_motion_ctrl.sv
// watermelon_motion_ctrl
//   Moves the watermelon sprite anchor around the 96x64 OLED, bouncing off the
//   edges. Start/pause/stop control, one position update every FRAME_DIV frame
//   ticks while running.
//   Ports:
//     CLOCK  in  system clock
//     RESET  in  synchronous active-high reset, overrides everything
//     bus    slave modport: frame_tick/start/pause/stop in;
//            leftX_watermelon, topY_watermelon, dir_x, dir_y, moving,
//            update_pulse out
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | anchor parked at INIT, frame ticks ignored, waits for start
//   RUN     | counts frame ticks, steps both axes every FRAME_DIV ticks
//   PAUSED  | anchor, directions and tick count frozen until start
module watermelon_motion_ctrl
  import watermelon_motion_ctrl_pkg::*;
(
  input logic                     CLOCK,
  input logic                     RESET,
  watermelon_motion_ctrl_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             load_init;
  logic             step_en;
  logic             update_q;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;
  logic             dir_x_q;
  logic             dir_y_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      update_q <= 1'b0;
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      update_q <= step_en;
    end
  end

  // Priority stop > pause > start in every state; a control pulse in RUN
  // also swallows a coincident frame tick.
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    load_init  = 1'b0;
    step_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.stop) begin
          load_init = 1'b1;
          div_next  = '0;
        end else if (bus.pause) begin
          state_next = ST_IDLE;
        end else if (bus.start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
          load_init  = 1'b1;
          div_next   = '0;
        end else if (bus.pause) begin
          state_next = ST_PAUSED;
        end else if (bus.frame_tick) begin
          if (div_cnt == DIV_LAST) begin
            div_next = '0;
            step_en  = 1'b1;
          end else begin
            div_next = div_cnt + DIV_W'(1);
          end
        end
      end
      ST_PAUSED: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
          load_init  = 1'b1;
          div_next   = '0;
        end else if (bus.pause) begin
          state_next = ST_PAUSED;
        end else if (bus.start) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_IDLE;
        load_init  = 1'b1;
        div_next   = '0;
      end
    endcase
  end

  watermelon_motion_ctrl_bounce_axis #(
    .W(X_W), .MAX(MAX_X), .STEP(STEP_X), .INIT(INIT_X)
  ) u_axis_x (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .load_init (load_init),
    .step_en   (step_en),
    .pos       (pos_x),
    .dir       (dir_x_q)
  );

  watermelon_motion_ctrl_bounce_axis #(
    .W(Y_W), .MAX(MAX_Y), .STEP(STEP_Y), .INIT(INIT_Y)
  ) u_axis_y (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .load_init (load_init),
    .step_en   (step_en),
    .pos       (pos_y),
    .dir       (dir_y_q)
  );

  assign bus.leftX_watermelon = pos_x;
  assign bus.topY_watermelon  = pos_y;
  assign bus.dir_x            = dir_x_q;
  assign bus.dir_y            = dir_y_q;
  assign bus.moving           = (state == ST_RUN);
  assign bus.update_pulse     = update_q;

endmodule

// File: tb/tb_watermelon_motion_ctrl.sv
module tb_watermelon_motion_ctrl;

  localparam int T_MAX_X  = 40;
  localparam int T_MAX_Y  = 6;
  localparam int T_STEP_X = 2;
  localparam int T_STEP_Y = 1;
  localparam int T_DIV    = 2;
  localparam int T_INIT_X = 20;
  localparam int T_INIT_Y = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  watermelon_motion_ctrl_if bus ();

  watermelon_motion_ctrl dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference model: mode 0 idle, 1 run, 2 paused; ticks counted since last update.
  int m_x = T_INIT_X, m_y = T_INIT_Y, m_ticks = 0, m_mode = 0;
  bit m_dx = 1'b1, m_dy = 1'b1, m_upd = 1'b0, m_valid = 1'b0;

  function automatic void bounce(inout int p, inout bit d, input int mx, input int st);
    if (d) begin
      if (p + st >= mx) begin p = mx; d = 1'b0; end
      else p = p + st;
    end else begin
      if (p <= st) begin p = 0; d = 1'b1; end
      else p = p - st;
    end
  endfunction

  always @(posedge clk) begin
    int x, y, tk, md;
    bit dx, dy, up;
    x = m_x; y = m_y; tk = m_ticks; md = m_mode; dx = m_dx; dy = m_dy; up = 1'b0;
    if (rst) begin
      x = T_INIT_X; y = T_INIT_Y; dx = 1'b1; dy = 1'b1; tk = 0; md = 0;
    end else if (bus.stop) begin
      x = T_INIT_X; y = T_INIT_Y; dx = 1'b1; dy = 1'b1; tk = 0; md = 0;
    end else if (bus.pause) begin
      if (md == 1) md = 2;
    end else if (bus.start && md != 1) begin
      md = 1;
    end else if (bus.frame_tick && md == 1) begin
      tk = tk + 1;
      if (tk == T_DIV) begin
        tk = 0;
        bounce(x, dx, T_MAX_X, T_STEP_X);
        bounce(y, dy, T_MAX_Y, T_STEP_Y);
        up = 1'b1;
      end
    end
    m_x <= x; m_y <= y; m_ticks <= tk; m_mode <= md;
    m_dx <= dx; m_dy <= dy; m_upd <= up;
    m_valid <= m_valid | rst;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_x",      int'(bus.leftX_watermelon), m_x);
      check("cmp_y",      int'(bus.topY_watermelon),  m_y);
      check("cmp_dir_x",  int'(bus.dir_x),            int'(m_dx));
      check("cmp_dir_y",  int'(bus.dir_y),            int'(m_dy));
      check("cmp_moving", int'(bus.moving),           (m_mode == 1) ? 1 : 0);
      check("cmp_update", int'(bus.update_pulse),     int'(m_upd));
    end
  end

  task automatic cyc(input bit t, input bit s, input bit p, input bit k);
    bus.frame_tick = t; bus.start = s; bus.pause = p; bus.stop = k;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
  endtask

  int ex[10] = '{24, 26, 28, 30, 32, 34, 36, 38, 40, 38};
  int ey[10] = '{5, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  initial begin
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    rst = 1'b1;
    repeat (2) cyc(0, 0, 0, 0);
    rst = 1'b0;
    check("rst_x", int'(bus.leftX_watermelon), 20);
    check("rst_y", int'(bus.topY_watermelon), 3);
    check("rst_moving", int'(bus.moving), 0);
    check("rst_dirs", int'({bus.dir_x, bus.dir_y}), 3);
    repeat (4) begin
      cyc(1, 0, 0, 0);
      check("idle_tick_x", int'(bus.leftX_watermelon), 20);
      check("idle_tick_upd", int'(bus.update_pulse), 0);
    end

    cyc(0, 1, 0, 0);
    check("start_moving", int'(bus.moving), 1);
    cyc(1, 0, 0, 0);
    check("first_tick_upd", int'(bus.update_pulse), 0);
    check("first_tick_x", int'(bus.leftX_watermelon), 20);
    cyc(1, 0, 0, 0);
    check("second_tick_x", int'(bus.leftX_watermelon), 22);
    check("second_tick_y", int'(bus.topY_watermelon), 4);
    check("second_tick_upd", int'(bus.update_pulse), 1);
    cyc(0, 0, 0, 0);
    check("upd_one_cycle", int'(bus.update_pulse), 0);

    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0);
      check("bounce_mid_upd", int'(bus.update_pulse), 0);
      cyc(1, 0, 0, 0);
      check("bounce_x", int'(bus.leftX_watermelon), ex[i]);
      check("bounce_y", int'(bus.topY_watermelon), ey[i]);
      check("bounce_upd", int'(bus.update_pulse), 1);
      if (i == 8) check("dir_x_at_max", int'(bus.dir_x), 0);
      if (i == 1) check("dir_y_at_max", int'(bus.dir_y), 0);
      if (i == 7) check("dir_y_at_zero", int'(bus.dir_y), 1);
    end

    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    check("pause_tick_x", int'(bus.leftX_watermelon), 38);
    check("pause_tick_y", int'(bus.topY_watermelon), 2);
    check("pause_tick_upd", int'(bus.update_pulse), 0);
    check("pause_moving", int'(bus.moving), 0);
    repeat (6) begin
      cyc(1, 0, 0, 0);
      check("paused_x", int'(bus.leftX_watermelon), 38);
      check("paused_upd", int'(bus.update_pulse), 0);
    end
    cyc(0, 1, 0, 0);
    check("resume_moving", int'(bus.moving), 1);
    cyc(1, 0, 0, 0);
    check("resume_x", int'(bus.leftX_watermelon), 36);
    check("resume_y", int'(bus.topY_watermelon), 3);
    check("resume_upd", int'(bus.update_pulse), 1);

    repeat (6) cyc(1, 0, 0, 0);
    check("pre_stop_x", int'(bus.leftX_watermelon), 30);
    check("pre_stop_dir_x", int'(bus.dir_x), 0);
    cyc(0, 0, 0, 1);
    check("stop_x", int'(bus.leftX_watermelon), 20);
    check("stop_y", int'(bus.topY_watermelon), 3);
    check("stop_dirs", int'({bus.dir_x, bus.dir_y}), 3);
    check("stop_moving", int'(bus.moving), 0);

    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 1, 0, 0);
    check("rst_run_x", int'(bus.leftX_watermelon), 20);
    check("rst_run_y", int'(bus.topY_watermelon), 3);
    check("rst_run_upd", int'(bus.update_pulse), 0);
    check("rst_run_moving", int'(bus.moving), 0);
    rst = 1'b0;

    repeat (3000) begin
      bit t, s, p, k;
      t = ($urandom_range(0, 99) < 45);
      s = ($urandom_range(0, 99) < 6);
      p = ($urandom_range(0, 99) < 3);
      k = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 999) < 3);
      cyc(t, s, p, k);
    end
    rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
